// File: rtl/cache_pkg.sv
// Shared types and helpers for the parametrised data cache controller.
// Holds the FSM state encoding and constant functions used for index/way widths.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Way index width, kept at least one bit so a direct-mapped build still has legal vectors.
  function automatic int way_idx_w(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/param_cache_controller_if.sv
// CPU-side and SRAM-side bus of the data cache controller.
// master = environment (CPU + SRAM), slave = cache controller.
interface param_cache_controller_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       write_data;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       read_data;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_write_data;
  logic              sram_write_en;
  logic              sram_read_en;
  logic [63:0]       sram_read_data;
  logic              sram_ready;

  modport master (
    output addr, write_data, MEM_R_EN, MEM_W_EN, sram_read_data, sram_ready,
    input  read_data, ready, sram_addr, sram_write_data, sram_write_en, sram_read_en
  );

  modport slave (
    input  addr, write_data, MEM_R_EN, MEM_W_EN, sram_read_data, sram_ready,
    output read_data, ready, sram_addr, sram_write_data, sram_write_en, sram_read_en
  );
endinterface

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU state; each tree bit points toward the less recently used half.
// Supports 1 (no state), 2 or 4 ways.
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [clog2(SETS)-1:0]      set_idx,
  input  logic                        access_valid,
  input  logic [way_idx_w(WAYS)-1:0]  access_way,
  output logic [way_idx_w(WAYS)-1:0]  victim_way
);

  generate
    if (WAYS == 1) begin : g_direct
      logic unused_plru;
      assign unused_plru = ^{clk, rst, set_idx, access_valid, access_way};
      assign victim_way  = '0;
    end else begin : g_tree
      logic [WAYS-2:0] bits_reg [SETS];
      logic [WAYS-2:0] bits_cur;
      logic [WAYS-2:0] bits_next;

      assign bits_cur = bits_reg[set_idx];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) bits_reg[s] <= '0;
        end else if (access_valid) begin
          bits_reg[set_idx] <= bits_next;
        end
      end

      if (WAYS == 2) begin : g_two
        always_comb begin
          bits_next  = ~access_way[0];
          victim_way = bits_cur[0];
        end
      end else begin : g_four
        always_comb begin
          bits_next    = bits_cur;
          bits_next[0] = ~access_way[1];
          if (!access_way[1]) bits_next[1] = ~access_way[0];
          else                bits_next[2] = ~access_way[0];
          victim_way = bits_cur[0] ? {1'b1, bits_cur[2]} : {1'b0, bits_cur[1]};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/param_cache_controller.sv
// N-way set-associative, write-through, no-write-allocate data cache in front of a 64-bit SRAM.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module param_cache_controller
  import cache_pkg::*;
#(
  parameter int                WAYS     = 2,
  parameter int                SETS     = 64,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = 1024
) (
  input logic                     clk,
  input logic                     rst,
  param_cache_controller_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int IDX_W = clog2(SETS);
  localparam int WAY_W = way_idx_w(WAYS);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;

  generate
    if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
      $error("param_cache_controller: WAYS must be 1, 2 or 4");
    end
    if (SETS < 2 || (1 << IDX_W) != SETS) begin : g_bad_sets
      $error("param_cache_controller: SETS must be a power of two >= 2");
    end
  endgenerate

  logic [ADDR_W-1:0] ea;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              word_sel;
  logic              unused_ea_bits;

  assign ea             = bus.addr - MEM_BASE;
  assign index          = ea[2+IDX_W:3];
  assign tag            = ea[ADDR_W-1:3+IDX_W];
  assign word_sel       = ea[2];
  assign unused_ea_bits = ^ea[1:0];

  state_t state_reg, state_next;

  logic [WAYS-1:0]        way_hit;
  logic [WAYS-1:0]        way_valid;
  logic [WAYS-1:0][63:0]  way_line;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [63:0]            hit_line;
  logic [31:0]            hit_word;
  logic                   has_invalid;
  logic [WAY_W-1:0]       invalid_way;
  logic [WAY_W-1:0]       plru_victim;
  logic [WAY_W-1:0]       fill_way;
  logic [WAY_W-1:0]       access_way;
  logic                   fill_we;
  logic                   wr_hit_we;
  logic                   rd_hit_idle;
  logic                   plru_access;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [63:0]      data_mem [SETS];
      logic [SETS-1:0]  valid_reg;
      logic [63:0]      line_wr;
      logic             fill_this;

      assign fill_this     = fill_we && (fill_way == WAY_W'(gi));
      assign way_line[gi]  = data_mem[index];
      assign way_valid[gi] = valid_reg[index];
      assign way_hit[gi]   = valid_reg[index] && (tag_mem[index] == tag);
      assign line_wr       = word_sel ? {bus.write_data, way_line[gi][31:0]}
                                      : {way_line[gi][63:32], bus.write_data};

      always_ff @(posedge clk) begin
        if (fill_this) begin
          tag_mem[index]  <= tag;
          data_mem[index] <= bus.sram_read_data;
        end else if (wr_hit_we && way_hit[gi]) begin
          data_mem[index] <= line_wr;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)           valid_reg        <= '0;
        else if (fill_this) valid_reg[index] <= 1'b1;
      end
    end
  endgenerate

  always_comb begin
    hit         = |way_hit;
    hit_way     = '0;
    hit_line    = '0;
    has_invalid = 1'b0;
    invalid_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_way  = WAY_W'(w);
        hit_line = way_line[w];
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        has_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
  end

  assign hit_word    = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_way    = has_invalid ? invalid_way : plru_victim;
  assign rd_hit_idle = (state_reg == IDLE) && bus.MEM_R_EN && !bus.MEM_W_EN && hit;
  assign plru_access = rd_hit_idle || fill_we || wr_hit_we;
  assign access_way  = fill_we ? fill_way : hit_way;

  cache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk          (clk),
    .rst          (rst),
    .set_idx      (index),
    .access_valid (plru_access),
    .access_way   (access_way),
    .victim_way   (plru_victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next         = state_reg;
    bus.ready          = 1'b0;
    bus.sram_read_en   = 1'b0;
    bus.sram_write_en  = 1'b0;
    bus.read_data      = hit ? hit_word : 32'd0;
    fill_we            = 1'b0;
    wr_hit_we          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.MEM_W_EN)      state_next = WRITE;
        else if (!bus.MEM_R_EN) bus.ready = 1'b1;
        else if (hit)           bus.ready = 1'b1;
        else                    state_next = FILL;
      end
      FILL: begin
        bus.sram_read_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready     = 1'b1;
          bus.read_data = word_sel ? bus.sram_read_data[63:32] : bus.sram_read_data[31:0];
          fill_we       = 1'b1;
          state_next    = IDLE;
        end
      end
      WRITE: begin
        bus.sram_write_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready  = 1'b1;
          wr_hit_we  = hit;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sram_addr       = bus.addr;
  assign bus.sram_write_data = bus.write_data;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (rd_hit_idle && hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      if (fill_we && miss_cnt_reg != 32'hFFFF_FFFF)    miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`endif

endmodule
